// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared types, widths and result formatting for the fc_g2 MAC engine
package fc_pkg;

    localparam int DATA_W   = 16;
    localparam int ACC_W    = 40;
    localparam int FRAC_DEF = 8;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 40'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -40'sd32768;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        EMIT  = 2'd3
    } fc_state_t;

    // Rescale the accumulator back to Q8.8, clamp to 16 bits, optional ReLU.
    // The shift is arithmetic so negative sums truncate toward minus infinity.
    function automatic logic [DATA_W-1:0] fc_result(
        input logic signed [ACC_W-1:0] acc,
        input int                      frac,
        input logic                    relu
    );
        logic signed [ACC_W-1:0] r;
        logic        [DATA_W-1:0] res;
        r = acc >>> frac;
        if (relu && (r < 0)) begin
            res = '0;
        end else if (r > SAT_MAX) begin
            res = 16'h7FFF;
        end else if (r < SAT_MIN) begin
            res = 16'h8000;
        end else begin
            res = r[DATA_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// rtl/fc_mac_lane.sv - one registered signed 16x16 multiplier lane
module fc_mac_lane
    import fc_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic        [DATA_W-1:0]   w,
    input  logic        [DATA_W-1:0]   x,
    output logic signed [2*DATA_W-1:0] p
);

    // Register the full-precision product of the returning memory words.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            p <= '0;
        end else begin
            p <= $signed(w) * $signed(x);
        end
    end

endmodule

// File: rtl/fc_g2_mac.sv
// rtl/fc_g2_mac.sv - fully-connected layer engine, two MACs per cycle, streamed Q8.8 results
module fc_g2_mac
    import fc_pkg::*;
#(
    parameter int N_IN  = 64,
    parameter int N_OUT = 8,
    parameter int FRAC  = FRAC_DEF,
    parameter int RELU  = 1
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [8:0]                 w_addr_a,
    output logic [8:0]                 w_addr_b,
    input  logic [DATA_W-1:0]          w_q_a,
    input  logic [DATA_W-1:0]          w_q_b,
    output logic [$clog2(N_IN)-1:0]    x_addr_a,
    output logic [$clog2(N_IN)-1:0]    x_addr_b,
    input  logic [DATA_W-1:0]          x_q_a,
    input  logic [DATA_W-1:0]          x_q_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(N_OUT)-1:0]   out_index,
    output logic [DATA_W-1:0]          out_data
);

    localparam int X_W   = $clog2(N_IN);
    localparam int O_W   = $clog2(N_OUT);
    localparam int PAIRS = N_IN / 2;
    localparam int I_W   = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int EXT_W = ACC_W - 2*DATA_W;

    fc_state_t state;
    fc_state_t state_next;

    logic [O_W-1:0] o;
    logic [I_W-1:0] i;
    logic           dc;
    logic           v_d1;
    logic           v_d2;

    logic signed [ACC_W-1:0]    acc;
    logic signed [2*DATA_W-1:0] pa;
    logic signed [2*DATA_W-1:0] pb;

    logic last_pair;
    logic last_neuron;
    logic accept;
    logic begin_layer;
    logic next_neuron;
    logic enter_run;

    logic           load_addr;
    logic [O_W-1:0] o_sel;
    logic [I_W-1:0] p_sel;
    logic [8:0]     w_next_a;
    logic [8:0]     w_next_b;
    logic [X_W-1:0] x_next_a;
    logic [X_W-1:0] x_next_b;

    assign last_pair   = (state == RUN) && (i == I_W'(PAIRS - 1));
    assign last_neuron = (o == O_W'(N_OUT - 1));
    assign accept      = (state == EMIT) && out_ready;
    assign begin_layer = (state == IDLE) && start;
    assign next_neuron = accept && !last_neuron;
    assign enter_run   = begin_layer || next_neuron;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: RUN walks the pairs, DRAIN waits two cycles, EMIT waits for the consumer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)     state_next = RUN;
            RUN:     if (last_pair) state_next = DRAIN;
            DRAIN:   if (dc)        state_next = EMIT;
            EMIT:    if (out_ready) state_next = last_neuron ? IDLE : RUN;
            default:                state_next = IDLE;
        endcase
    end

    // FSM outputs that depend only on the current state.
    always_comb begin
        busy      = (state != IDLE);
        out_valid = (state == EMIT);
    end

    // Neuron, pair and drain counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            o  <= '0;
            i  <= '0;
            dc <= 1'b0;
        end else begin
            dc <= (state == DRAIN) ? ~dc : 1'b0;
            if (begin_layer) begin
                o <= '0;
                i <= '0;
            end else if (state == RUN) begin
                i <= last_pair ? '0 : i + 1'b1;
            end else if (next_neuron) begin
                o <= o + 1'b1;
                i <= '0;
            end
        end
    end

    // Pick the pair to present next cycle; the address registers only move on these events.
    always_comb begin
        load_addr = 1'b0;
        o_sel     = o;
        p_sel     = i;
        if (begin_layer) begin
            load_addr = 1'b1;
            o_sel     = '0;
            p_sel     = '0;
        end else if ((state == RUN) && !last_pair) begin
            load_addr = 1'b1;
            p_sel     = i + 1'b1;
        end else if (next_neuron) begin
            load_addr = 1'b1;
            o_sel     = o + 1'b1;
            p_sel     = '0;
        end
        w_next_a = 9'(int'(o_sel) * N_IN + 2 * int'(p_sel));
        w_next_b = 9'(int'(o_sel) * N_IN + 2 * int'(p_sel) + 1);
        x_next_a = X_W'(2 * int'(p_sel));
        x_next_b = X_W'(2 * int'(p_sel) + 1);
    end

    // Address registers, held between loads so a stalled EMIT issues nothing new.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            w_addr_a <= '0;
            w_addr_b <= '0;
            x_addr_a <= '0;
            x_addr_b <= '0;
        end else if (load_addr) begin
            w_addr_a <= w_next_a;
            w_addr_b <= w_next_b;
            x_addr_a <= x_next_a;
            x_addr_b <= x_next_b;
        end
    end

    // Valid tracking: address in RUN, data a cycle later, products a cycle after that.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            v_d1 <= 1'b0;
            v_d2 <= 1'b0;
        end else begin
            v_d1 <= (state == RUN);
            v_d2 <= v_d1;
        end
    end

    fc_mac_lane u_lane_a (
        .clock   (clock),
        .reset_n (reset_n),
        .w       (w_q_a),
        .x       (x_q_a),
        .p       (pa)
    );

    fc_mac_lane u_lane_b (
        .clock   (clock),
        .reset_n (reset_n),
        .w       (w_q_b),
        .x       (x_q_b),
        .p       (pb)
    );

    // Accumulator: cleared as each neuron starts, summing both lanes while products are valid.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
        end else if (enter_run) begin
            acc <= '0;
        end else if (v_d2) begin
            acc <= acc + {{EXT_W{pa[2*DATA_W-1]}}, pa} + {{EXT_W{pb[2*DATA_W-1]}}, pb};
        end
    end

    // One-cycle completion pulse after the last result is taken.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            done <= 1'b0;
        end else begin
            done <= accept && last_neuron;
        end
    end

    assign out_index = o;
    assign out_data  = fc_result(acc, FRAC, (RELU != 0));

endmodule

// File: tb/tb_fc_g2_mac.sv
// tb/tb_fc_g2_mac.sv - scoreboard bench for fc_g2_mac with ReLU off and on instances
module tb_fc_g2_mac;

    localparam int N_IN  = 64;
    localparam int N_OUT = 8;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic out_ready = 1'b1;

    always #5 clock = ~clock;

    logic [15:0] wmem [0:511];
    logic [15:0] xmem [0:63];

    logic        busy0, done0, ov0, busy1, done1, ov1;
    logic [8:0]  wa0, wb0, wa1, wb1;
    logic [5:0]  xa0, xb0, xa1, xb1;
    logic [2:0]  oi0, oi1;
    logic [15:0] od0, od1;
    logic [15:0] wqa0, wqb0, xqa0, xqb0, wqa1, wqb1, xqa1, xqb1;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  idx;
        logic [15:0] d0;
        logic [15:0] d1;
    } exp_t;
    exp_t sb [$];

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        wqa0 <= wmem[wa0]; wqb0 <= wmem[wb0]; xqa0 <= xmem[xa0]; xqb0 <= xmem[xb0];
        wqa1 <= wmem[wa1]; wqb1 <= wmem[wb1]; xqa1 <= xmem[xa1]; xqb1 <= xmem[xb1];
    end

    fc_g2_mac #(.N_IN(N_IN), .N_OUT(N_OUT), .FRAC(8), .RELU(0)) u0 (
        .clock(clock), .reset_n(reset_n), .start(start), .busy(busy0), .done(done0),
        .w_addr_a(wa0), .w_addr_b(wb0), .w_q_a(wqa0), .w_q_b(wqb0),
        .x_addr_a(xa0), .x_addr_b(xb0), .x_q_a(xqa0), .x_q_b(xqb0),
        .out_valid(ov0), .out_ready(out_ready), .out_index(oi0), .out_data(od0)
    );

    fc_g2_mac #(.N_IN(N_IN), .N_OUT(N_OUT), .FRAC(8), .RELU(1)) u1 (
        .clock(clock), .reset_n(reset_n), .start(start), .busy(busy1), .done(done1),
        .w_addr_a(wa1), .w_addr_b(wb1), .w_q_a(wqa1), .w_q_b(wqb1),
        .x_addr_a(xa1), .x_addr_b(xb1), .x_q_a(xqa1), .x_q_b(xqb1),
        .out_valid(ov1), .out_ready(out_ready), .out_index(oi1), .out_data(od1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input int o, input bit relu);
        longint acc;
        longint r;
        acc = 0;
        for (int j = 0; j < N_IN; j++)
            acc += longint'($signed(wmem[o*N_IN + j])) * longint'($signed(xmem[j]));
        r = acc >>> 8;
        if (relu && r < 0) r = 0;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r[15:0];
    endfunction

    task automatic fill(input logic [15:0] wv, input logic [15:0] xv);
        for (int k = 0; k < 512; k++) wmem[k] = wv;
        for (int k = 0; k < N_IN; k++) xmem[k] = xv;
    endtask

    task automatic fill_diag();
        for (int k = 0; k < 512; k++) wmem[k] = ((k % N_IN) == (k / N_IN)) ? 16'h0100 : 16'h0000;
        for (int k = 0; k < N_IN; k++) xmem[k] = 16'(k << 8);
    endtask

    task automatic fill_rand();
        for (int k = 0; k < 512; k++) wmem[k] = 16'($urandom_range(0, 1023)) - 16'd512;
        for (int k = 0; k < N_IN; k++) xmem[k] = 16'($urandom_range(0, 1023)) - 16'd512;
    endtask

    task automatic run_layer(input bit stall3, input bit pulse_run, input bit abort5, input bit check_time);
        int t0, first, nres, guard, seen;
        bit stalled, got_done;
        exp_t e;
        logic [15:0] sv_d;
        logic [8:0]  sv_w;
        sb.delete();
        for (int o = 0; o < N_OUT; o++) begin
            e.idx = 3'(o);
            e.d0  = model(o, 1'b0);
            e.d1  = model(o, 1'b1);
            sb.push_back(e);
        end
        @(negedge clock);
        start = 1'b1;
        t0 = cyc;
        @(negedge clock);
        start = 1'b0;
        first = -1; nres = 0; stalled = 0; got_done = 0; guard = 0;
        while (guard < 1500 && !got_done) begin
            start = (pulse_run && cyc == t0 + 5) ? 1'b1 : 1'b0;
            if (done0) begin
                got_done = 1;
            end else begin
                if (abort5 && busy0 && oi0 == 3'd5 && xa0 == 6'd20) begin
                    reset_n = 1'b0;
                    #1;
                    chk("abort_reset_values", {busy0, done0, ov0, oi0, od0, wa0, wb0, xa0, xb0}, 64'd0);
                    chk("abort_reset_values_relu", {busy1, ov1, oi1, od1, wa1}, 64'd0);
                    repeat (3) @(negedge clock);
                    reset_n = 1'b1;
                    seen = 0;
                    repeat (100) begin
                        @(negedge clock);
                        if (ov0 || done0 || busy0) seen++;
                    end
                    chk("abort_no_result", seen, 0);
                    sb.delete();
                    return;
                end
                if (ov0 && first < 0) first = cyc;
                if (stall3 && ov0 && oi0 == 3'd3 && !stalled) begin
                    stalled = 1;
                    out_ready = 1'b0;
                    sv_d = od0;
                    sv_w = wa0;
                    repeat (10) begin
                        @(negedge clock);
                        chk("stall_hold", {ov0, oi0, od0, wa0, xa0}, {1'b1, 3'd3, sv_d, sv_w, 6'd62});
                    end
                    out_ready = 1'b1;
                end
                if (ov0 && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("extra_result", sb.size(), 1);
                    end else begin
                        e = sb.pop_front();
                        chk("out_index", oi0, e.idx);
                        chk("out_data_norelu", od0, e.d0);
                        chk("out_data_relu", {ov1, oi1, od1}, {1'b1, e.idx, e.d1});
                    end
                    nres++;
                end
                @(negedge clock);
                guard++;
            end
        end
        start = 1'b0;
        chk("layer_done_seen", got_done, 1);
        chk("result_count", nres, N_OUT);
        chk("done_busy", {done0, busy0, done1}, 3'b101);
        if (stall3) chk("stall_happened", stalled, 1);
        if (check_time) begin
            chk("first_valid_latency", first - t0, 35);
            chk("done_latency", cyc - t0, 281);
        end
        @(negedge clock);
        chk("done_pulse_width", done0, 0);
        if (pulse_run) begin
            seen = 0;
            repeat (5) begin
                @(negedge clock);
                if (busy0 || ov0) seen++;
            end
            chk("no_queued_start", seen, 0);
        end
    endtask

    initial begin
        fill(16'h0000, 16'h0000);
        #2;
        chk("reset_values", {busy0, done0, ov0, oi0, od0, wa0, wb0, xa0, xb0}, 64'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        fill(16'h0100, 16'h0100);
        run_layer(0, 0, 0, 1);

        fill_diag();
        run_layer(1, 0, 0, 0);

        fill(16'h7FFF, 16'h7FFF);
        run_layer(0, 1, 0, 0);

        fill(16'h8000, 16'h7FFF);
        run_layer(0, 0, 0, 0);

        fill_rand();
        run_layer(0, 0, 0, 1);

        fill_diag();
        run_layer(0, 0, 1, 0);
        run_layer(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fc_g2_mac.md
# fc_g2_mac

Fully-connected layer engine that sits directly downstream of the `fc_g2_mem` weight ROM. It drives both ROM read ports and the two read ports of the activation buffer, and computes two signed Q8.8 multiply-accumulates per cycle. It then streams one saturated, optionally ReLU'd Q8.8 result per output neuron to the next stage over a valid/ready handshake.

## Interface
Parameters:
- `N_IN`, 64: inputs per neuron; even; `N_IN*N_OUT` ≤ 512.
- `N_OUT`, 8: output neurons.
- `FRAC`, 8: fractional bits of operands and result.
- `RELU`, 1: 1 clamps negative results to 0.

Ports:
- `clock` in 1: single clock; all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request; honoured only in IDLE.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse after the last result is accepted.
- `w_addr_a`, `w_addr_b` out 9: weight ROM addresses.
- `w_q_a`, `w_q_b` in 16: ROM data, valid one cycle after the address.
- `x_addr_a`, `x_addr_b` out $clog2(N_IN): activation buffer addresses.
- `x_q_a`, `x_q_b` in 16: activations, one-cycle read latency.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts when high with `out_valid`.
- `out_index` out $clog2(N_OUT): neuron number of the current result.
- `out_data` out 16: signed Q8.8 result.

## Operation
- States:
  - IDLE: `start` → RUN; clears neuron counter `o` and pair counter `i`.
  - RUN: issues one address pair per cycle for `i` = 0..N_IN/2−1:
    - `w_addr_a` = o*N_IN + 2i, `w_addr_b` = o*N_IN + 2i + 1.
    - `x_addr_a` = 2i, `x_addr_b` = 2i + 1.
    - After the last pair → DRAIN.
  - DRAIN: exactly 2 cycles, letting the pipeline empty → EMIT.
  - EMIT: `out_valid` = 1. On `out_ready`:
    - if `o` = N_OUT−1 → IDLE with `done` pulse;
    - else increment `o`, clear the accumulator → RUN.
- Pipeline:
  - Stage 1: address registered.
  - Stage 2: memory data returns; products `pa` = `w_q_a`*`x_q_a` and `pb` = `w_q_b`*`x_q_b` (signed 16×16 → 32) are registered.
  - Stage 3: `acc` += `pa` + `pb`.
- `acc` is signed 40-bit and cleared on entry to RUN for each neuron; it cannot overflow for N_IN ≤ 256.
- Result computation:
  - `r` = `acc` >>> FRAC (arithmetic shift, truncation toward −∞).
  - Saturate `r` to [−32768, 32767].
  - If RELU and `r` < 0, output 0.
- `out_data` is computed combinationally from `acc`. `acc` is stable throughout EMIT.
- `start` while `busy` is ignored; no queuing.
- Address outputs hold their last value outside RUN. The ROM and buffer are read-only, so stray reads are harmless.
- `out_index` = `o`.

## Timing
- Reset values:
  - state IDLE; `busy`, `done`, `out_valid` all 0;
  - `out_index`, `out_data`, `acc`, all address outputs all 0.
- Reset asserted mid-run aborts immediately. No result or `done` follows, and the next `start` begins from neuron 0.
- `start` sampled in cycle T:
  - RUN occupies T+1 .. T+N_IN/2;
  - DRAIN occupies the next 2 cycles;
  - first `out_valid` in cycle T+N_IN/2+3.
- Per-neuron latency is N_IN/2 + 3 cycles with `out_ready` held high. Defaults: 35 cycles per neuron, 280 cycles per layer.
- `done` is asserted in the cycle after the final handshake, and `busy` falls in that same cycle.
- While `out_ready` = 0, `out_valid`, `out_index` and `out_data` hold stable. No new address is issued.
- A new `start` is accepted in the cycle after `done`.

## Structure
- Package `fc_pkg` holds:
  - state enum (IDLE, RUN, DRAIN, EMIT);
  - `DATA_W` = 16, `ACC_W` = 40, default `FRAC`;
  - the shift/saturate/ReLU function.
- Sub-module `fc_mac_lane`: one registered signed multiplier lane, instantiated twice.
- FSM, counters, address generation and the accumulator live in the top level.

## Test plan
- All weights 0x0100 and all activations 0x0100, RELU = 0, `out_ready` high → eight results of 0x4000, indices 0..7, first `out_valid` 35 cycles after `start`, `done` at cycle 281.
- Weight[o*64+j] = 0x0100 only for j = o, else 0; activation[j] = j<<8 → `out_data` = o<<8 for neuron o.
- All weights and activations 0x7FFF → every result saturates to 0x7FFF. Weights 0x8000 with activations 0x7FFF and RELU = 0 → 0x8000; same with RELU = 1 → 0x0000.
- `out_ready` held low for 10 cycles during neuron 3 → `out_valid`, `out_index` = 3 and `out_data` stay constant, no address changes; the handshake resumes correctly.
- `start` pulsed during RUN → ignored, still exactly 8 results.
- `reset_n` low during neuron 5 → all outputs at reset values. A new `start` then yields indices 0..7 with correct data.
